any1_branch_predictor: RTL

Predicts branch direction at fetch for the ANY-1 pipeline. It is the producing end of the branch-outcome path: it issues predicted take/not-take decisions, and later consumes the resolved outcome from the execute-stage branch evaluator. The predictor is a gshare table of 2-bit saturating counters indexed by PC XOR global history. The table is trained from resolved outcomes and swept to a known state after reset.

---
 rtl/any1_branch_predictor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/any1_branch_predictor.sv
// gshare branch direction predictor for the ANY-1 fetch stage: a table of 2-bit
// saturating counters indexed by PC ^ global history and trained from resolved branches.
module any1_branch_predictor #(
    parameter  int ENTRIES  = 512,
    parameter  int AW       = 32,
    parameter  int GHR_BITS = 8,
    localparam int IDXB     = $clog2(ENTRIES)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pv_i,
    input  logic [AW-1:0]   pc_i,
    output logic            pvld_o,
    output logic            pt_o,
    output logic [1:0]      pctr_o,
    output logic [IDXB-1:0] pidx_o,
    input  logic            uv_i,
    input  logic [IDXB-1:0] uidx_i,
    input  logic [1:0]      uctr_i,
    input  logic            utakb_i,
    input  logic            upt_i,
    output logic            ready_o,
    output logic [31:0]     mispred_o
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state;
    logic [IDXB-1:0]     r_sweep;
    logic                r_ready;
    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_mispred;
    logic [1:0]          r_table [ENTRIES];
    logic [1:0]          r_ram_q;
    logic                r_src_ram;
    logic [1:0]          r_fix_ctr;
    logic                r_pvld;
    logic [IDXB-1:0]     r_pidx;

    logic                w_run;
    logic [IDXB-1:0]     w_idx;
    logic                w_upd;
    logic [1:0]          w_new_ctr;
    logic                w_we;
    logic [IDXB-1:0]     w_waddr;
    logic [1:0]          w_wdata;
    logic [GHR_BITS-1:0] w_ghr_next;
    logic                w_unused_pc;

    assign w_run       = (r_state == S_RUN);
    assign w_idx       = pc_i[IDXB+1:2] ^ IDXB'(r_ghr);
    assign w_upd       = uv_i & w_run;
    assign w_unused_pc = ^{pc_i[AW-1:IDXB+2], pc_i[1:0]};

    always_comb begin
        w_new_ctr = uctr_i;
        if (utakb_i) begin
            if (uctr_i != 2'd3) w_new_ctr = uctr_i + 2'd1;
        end else begin
            if (uctr_i != 2'd0) w_new_ctr = uctr_i - 2'd1;
        end
    end

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign w_ghr_next = utakb_i;
        end else begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[GHR_BITS-2:0], utakb_i};
        end
    endgenerate

    // Single write port: the init sweep owns it in INIT, resolved updates in RUN.
    assign w_we    = !w_run || uv_i;
    assign w_waddr = w_run ? uidx_i : r_sweep;
    assign w_wdata = w_run ? w_new_ctr : 2'b01;

    always_ff @(posedge clk_i) begin
        if (w_we) r_table[w_waddr] <= w_wdata;
    end

    // Registered read port; a same-cycle write to the same index is not forwarded.
    always_ff @(posedge clk_i) begin
        if (pv_i && w_run) r_ram_q <= r_table[w_idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_INIT;
            r_sweep <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_sweep <= r_sweep + IDXB'(1);
                    if (r_sweep == IDXB'(ENTRIES - 1)) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: r_ready <= 1'b1;
                default: r_state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr     <= '0;
            r_mispred <= '0;
        end else if (w_upd) begin
            r_ghr <= w_ghr_next;
            if ((utakb_i != upt_i) && (r_mispred != 32'hFFFF_FFFF))
                r_mispred <= r_mispred + 32'd1;
        end
    end

    // r_src_ram selects the RAM output; INIT-time requests report a fixed weakly-not-taken value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pvld    <= 1'b0;
            r_src_ram <= 1'b0;
            r_fix_ctr <= 2'b00;
            r_pidx    <= '0;
        end else begin
            r_pvld <= pv_i;
            if (pv_i) begin
                r_src_ram <= w_run;
                r_pidx    <= w_idx;
                if (!w_run) r_fix_ctr <= 2'b01;
            end
        end
    end

    assign pvld_o    = r_pvld;
    assign pctr_o    = r_src_ram ? r_ram_q : r_fix_ctr;
    assign pt_o      = pctr_o[1];
    assign pidx_o    = r_pidx;
    assign ready_o   = r_ready;
    assign mispred_o = r_mispred;

endmodule
